xwraddrgen: RTL and testbench
=============================

Name: xwraddrgen

Overview:
- Write-side counterpart of the Versat read address generator.
- Consumes a valid-qualified data stream and writes it into a destination memory port using the same iterations/period/duty/delay/start/shift/incr access pattern.
- The read generator produces addresses against time; this block advances its pattern once per accepted input beat.
- Sits between a functional unit output and a data-memory write port.

Parameters:
MEM_ADDR_W, 10, memory address width and iteration counter width
PERIOD_W, 10, width of period/duty/delay counters
DATA_W, 32, stream and memory data width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
init  in  1  load pattern counters from configuration (IDLE only)
run  in  1  start pattern (pulse)
pause  in  1  freeze all pattern state; beats not accepted
iterations  in  MEM_ADDR_W  number of periods
period  in  PERIOD_W  beats per period
duty  in  PERIOD_W  beats written per period (first duty beats)
delay  in  PERIOD_W  initial beats discarded after run
start  in  MEM_ADDR_W  first write address
shift  in  MEM_ADDR_W signed  extra address offset at period end
incr  in  MEM_ADDR_W signed  address step per written beat
in_valid  in  1  input beat present
in_data  in  DATA_W  input beat data
addr  out  MEM_ADDR_W  write address (registered)
we  out  1  write enable (registered)
wdata  out  DATA_W  write data (registered)
done  out  1  pattern complete / idle

Behaviour:
- Reset (rst low, async): state IDLE, we=0, addr=0, wdata=0, done=1, all counters 0.
- States: IDLE, SKIP, RUN.
- IDLE:
  - done=1, we=0.
  - init: cur_addr=start, iter=1, slot=1, skip_cnt=delay.
  - run: done=0 next cycle. Next state is SKIP if delay!=0, else RUN.
  - init and run in the same cycle: init values are used.
- Accepted beat: in_valid=1 and pause=0 in SKIP or RUN. Beats in IDLE or while pause=1 are dropped.
- SKIP:
  - Each accepted beat decrements skip_cnt, no write.
  - The beat that takes skip_cnt to 0 moves to RUN.
- RUN, per accepted beat:
  - If slot<=duty: next cycle we=1, addr=cur_addr, wdata=in_data; cur_addr+=incr.
  - If slot>duty: no write.
  - If slot==period: slot=1, cur_addr+=shift, iter+=1. Otherwise slot+=1.
  - Cycles without an accepted beat give we=0 and leave addr/wdata holding.
- Latency: exactly 1 cycle from accepted beat to we/addr/wdata.
- Arithmetic: address sums are modulo 2^MEM_ADDR_W; incr and shift are sign-extended two's complement. The shift is added after the incr of the same beat.
- Boundaries:
  - period==0 is treated as 1.
  - duty>period is clamped to period.
  - duty==0: no writes, pattern still completes.
  - iterations==0 is treated as 1.
- Completion: the accepted beat with slot==period and iter==iterations ends the pattern.
  - If run is high in that cycle: reload cur_addr=start, iter=1, slot=1, stay RUN, done stays 0. delay is not re-applied.
  - Otherwise: next state IDLE, done=1 in the same cycle as the final we.
- run while in SKIP/RUN (other than the completion beat) is ignored.
- pause holds state, counters and done. we is forced 0 in the cycle after a paused cycle.
- Reset mid-operation aborts immediately to reset values. The partial write in flight is cancelled (we=0).

Optional Feature:
- Macro XWRADDRGEN_ERR_EN.
- Defined:
  - Adds output port err (1 bit), reset 0, sticky.
  - err is set the cycle after in_valid=1 is seen in IDLE, or in SKIP/RUN with pause=1 (dropped beat).
  - err is cleared by init.
- Undefined: port err absent; dropped beats are silently discarded; behaviour otherwise identical.

Test Plan:
- Basic pattern: start=8, incr=1, shift=0, period=4, duty=2, iterations=3, delay=0, 12 contiguous beats D0..D11 -> writes (8,D0),(9,D1),(10,D4),(11,D5),(12,D8),(13,D9); done=1 with the last we; 6 we pulses total.
- Delay and gaps: delay=3, period=duty=2, iterations=2, start=0, incr=2, with in_valid toggling every other cycle -> first 3 beats discarded; writes at 0,2,4,6 one cycle after beats 4..7.
- Negative stride and wrap: MEM_ADDR_W=10, start=2, incr=-1, shift=5, period=duty=3, iterations=2 -> addresses 2,1,0,1023? No: within period 2,1,0, then cur=1023+5=4; second period 4,3,2.
- Back-to-back run: run asserted on the final beat of iterations=2 -> no IDLE cycle, done stays 0, next write address=start; done=1 only after the second pass completes.
- Pause and reset: pause=1 for 5 cycles mid-period with in_valid=1 -> no we, slot/addr unchanged; err=1 if XWRADDRGEN_ERR_EN. Then rst low mid-RUN -> we=0, done=1, addr=0 immediately.
- Degenerate: duty=0, period=3, iterations=2 -> 6 beats accepted, zero writes, done=1 after the 6th beat; duty=7, period=3 -> behaves as duty=3.

Source files
------------

// File: rtl/xwraddrgen_if.sv
// Stream-in / memory-write-out bundle for xwraddrgen.
// The master side drives the input beat stream and observes the write port.
interface xwraddrgen_if #(
  parameter int MEM_ADDR_W = 10,
  parameter int DATA_W     = 32
);
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic [MEM_ADDR_W-1:0] addr;
  logic                  we;
  logic [DATA_W-1:0]     wdata;

  modport master (output in_valid, in_data, input addr, we, wdata);
  modport slave  (input in_valid, in_data, output addr, we, wdata);
endinterface

// File: rtl/xwraddrgen.sv
// Write-side Versat address generator, advanced once per accepted beat; write port registered (1 cycle).
// No backpressure: beats in IDLE or under pause are dropped (flagged on err when XWRADDRGEN_ERR_EN is defined).
module xwraddrgen #(
  parameter int MEM_ADDR_W = 10,
  parameter int PERIOD_W   = 10,
  parameter int DATA_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init,
  input  logic                         run,
  input  logic                         pause,
  input  logic        [MEM_ADDR_W-1:0] iterations,
  input  logic        [PERIOD_W-1:0]   period,
  input  logic        [PERIOD_W-1:0]   duty,
  input  logic        [PERIOD_W-1:0]   delay,
  input  logic        [MEM_ADDR_W-1:0] start,
  input  logic signed [MEM_ADDR_W-1:0] shift,
  input  logic signed [MEM_ADDR_W-1:0] incr,
  xwraddrgen_if.slave                  bus,
  output logic                         done
`ifdef XWRADDRGEN_ERR_EN
  ,
  output logic                         err
`endif
);

  typedef enum logic [1:0] {IDLE, SKIP, RUN} state_t;

  state_t                state, state_nxt;
  logic [MEM_ADDR_W-1:0] cur_addr;
  logic [MEM_ADDR_W-1:0] iter;
  logic [PERIOD_W-1:0]   slot;
  logic [PERIOD_W-1:0]   skip_cnt;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  we_q;

  logic [PERIOD_W-1:0]   period_eff;
  logic [PERIOD_W-1:0]   duty_eff;
  logic [MEM_ADDR_W-1:0] iter_eff;
  logic                  beat;
  logic                  last_slot;
  logic                  pat_end;
  logic                  wr_beat;

  // Degenerate configurations collapse onto the nearest meaningful pattern.
  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
  assign duty_eff   = (duty > period_eff) ? period_eff : duty;
  assign iter_eff   = (iterations == '0) ? MEM_ADDR_W'(1) : iterations;

  assign beat      = (state != IDLE) && bus.in_valid && !pause;
  assign last_slot = (slot >= period_eff);
  assign pat_end   = (state == RUN) && beat && last_slot && (iter >= iter_eff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = (delay != '0) ? SKIP : RUN;
      SKIP:    if (beat && (skip_cnt <= PERIOD_W'(1))) state_nxt = RUN;
      RUN:     if (pat_end && !run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done    = (state == IDLE);
    wr_beat = (state == RUN) && beat && (slot != '0) && (slot <= duty_eff);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr <= '0;
      iter     <= '0;
      slot     <= '0;
      skip_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      we_q <= wr_beat;
      if (wr_beat) begin
        addr_q  <= cur_addr;
        wdata_q <= bus.in_data;
      end
      if (state == IDLE) begin
        if (init) begin
          cur_addr <= start;
          iter     <= MEM_ADDR_W'(1);
          slot     <= PERIOD_W'(1);
          skip_cnt <= delay;
        end
      end else if (state == SKIP) begin
        if (beat) skip_cnt <= skip_cnt - PERIOD_W'(1);
      end else if (beat) begin
        if (pat_end && run) begin
          // Back-to-back restart: the delay phase is not repeated.
          cur_addr <= start;
          iter     <= MEM_ADDR_W'(1);
          slot     <= PERIOD_W'(1);
        end else begin
          cur_addr <= cur_addr + (wr_beat ? incr : '0) + (last_slot ? shift : '0);
          if (last_slot) begin
            slot <= PERIOD_W'(1);
            iter <= iter + MEM_ADDR_W'(1);
          end else begin
            slot <= slot + PERIOD_W'(1);
          end
        end
      end
    end
  end

  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.we    = we_q;

`ifdef XWRADDRGEN_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= (err & ~init) | (bus.in_valid & ((state == IDLE) | pause));
  end
`endif

endmodule

// File: tb/tb_xwraddrgen.sv
// Randomized and directed bench for xwraddrgen; expected writes come from an index-arithmetic pattern model.
`timescale 1ns/1ps
module tb_xwraddrgen;
  localparam int AW = 10;
  localparam int PW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init = 1'b0;
  logic          run = 1'b0;
  logic          pause = 1'b0;
  logic [AW-1:0] iterations = '0;
  logic [PW-1:0] period = '0;
  logic [PW-1:0] duty = '0;
  logic [PW-1:0] delay = '0;
  logic [AW-1:0] start = '0;
  logic [AW-1:0] shift = '0;
  logic [AW-1:0] incr = '0;
  logic          done;
`ifdef XWRADDRGEN_ERR_EN
  logic          err;
`endif

  xwraddrgen_if #(.MEM_ADDR_W(AW), .DATA_W(DW)) bus();

  xwraddrgen #(.MEM_ADDR_W(AW), .PERIOD_W(PW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .init(init), .run(run), .pause(pause),
    .iterations(iterations), .period(period), .duty(duty), .delay(delay),
    .start(start), .shift(shift), .incr(incr), .bus(bus), .done(done)
`ifdef XWRADDRGEN_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_we = 0;
  int   we_mark;

  bit   m_active = 1'b0;
  bit   m_err = 1'b0;
  int   m_skip = 0;
  int   m_idx = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic int p_eff();
    return (period == '0) ? 1 : int'(period);
  endfunction
  function automatic int d_eff();
    return (int'(duty) > p_eff()) ? p_eff() : int'(duty);
  endfunction
  function automatic int i_eff();
    return (iterations == '0) ? 1 : int'(iterations);
  endfunction
  function automatic bit is_final();
    return m_active && (m_skip == 0) && (m_idx == i_eff() * p_eff() - 1);
  endfunction

  // Beat k of a pass lands in period k/p at slot k%p; each full period moves the base by duty*incr+shift.
  task automatic model_beat(input logic [DW-1:0] d, input bit rn);
    int p, dd, j, n, si, sh;
    bit fin;
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    p   = p_eff();
    dd  = d_eff();
    j   = m_idx % p;
    n   = m_idx / p;
    si  = int'($signed(incr));
    sh  = int'($signed(shift));
    fin = (m_idx == i_eff() * p - 1);
    if (j < dd) begin
      exp_t e;
      e.a    = AW'(int'(start) + n * (dd * si + sh) + j * si);
      e.d    = d;
      e.last = fin && !rn;
      sb.push_back(e);
    end
    m_idx++;
    if (fin) begin
      m_idx = 0;
      if (!rn) m_active = 1'b0;
    end
  endtask

  task automatic cyc(input bit v, input bit ps, input bit rn, input bit it);
    logic [DW-1:0] d;
    bit dropped;
    d            = $urandom;
    bus.in_valid = v;
    bus.in_data  = d;
    pause        = ps;
    run          = rn;
    init         = it;
    @(posedge clk);
    dropped = v && (!m_active || ps);
    if (it) m_err = 1'b0;
    if (dropped) m_err = 1'b1;
    if (!m_active) begin
      if (it) begin
        m_skip = int'(delay);
        m_idx  = 0;
      end
      if (rn) m_active = 1'b1;
    end else if (v && !ps) begin
      model_beat(d, rn);
    end
    #1;
    chk("done", {63'd0, done}, {63'd0, !m_active});
`ifdef XWRADDRGEN_ERR_EN
    chk("err", {63'd0, err}, {63'd0, m_err});
`endif
    bus.in_valid = 1'b0;
    pause        = 1'b0;
    run          = 1'b0;
    init         = 1'b0;
  endtask

  task automatic setcfg(input int st, input int inc, input int sh, input int per,
                        input int du, input int it, input int dl);
    start      = AW'(st);
    incr       = AW'(inc);
    shift      = AW'(sh);
    period     = PW'(per);
    duty       = PW'(du);
    iterations = AW'(it);
    delay      = PW'(dl);
  endtask

  task automatic drain_check(input string nm, input int writes);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk({nm, "_we_count"}, 64'(n_we - we_mark), 64'(writes));
    chk({nm, "_pending"}, 64'(sb.size()), 64'd0);
    we_mark = n_we;
  endtask

  always @(negedge clk) begin
    if (rst && bus.we === 1'b1) begin
      n_we++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_we: addr=%0h wdata=%0h, expected no write", bus.addr, bus.wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 64'(bus.addr), 64'(mon_e.a));
        chk("wr_data", 64'(bus.wdata), 64'(mon_e.d));
        chk("done_at_we", {63'd0, done}, {63'd0, mon_e.last});
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {63'd0, done}, 64'd1);
    chk("rst_we", {63'd0, bus.we}, 64'd0);
    chk("rst_addr", 64'(bus.addr), 64'd0);
    chk("rst_wdata", 64'(bus.wdata), 64'd0);
`ifdef XWRADDRGEN_ERR_EN
    chk("rst_err", {63'd0, err}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    we_mark = n_we;

    // Basic pattern
    setcfg(8, 1, 0, 4, 2, 3, 0);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);
    drain_check("basic", 6);

    // Delay with gapped input
    setcfg(0, 2, 0, 2, 2, 2, 3);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 16; i++) cyc(i % 2 == 0, 0, 0, 0);
    drain_check("delay_gaps", 4);

    // Negative stride with wrap below zero
    setcfg(2, -1, 5, 3, 3, 2, 0);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
    drain_check("neg_wrap", 6);

    // Back-to-back run on the completion beat
    setcfg(100, 3, 0, 2, 2, 2, 0);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, i == 3 && is_final(), 0);
    drain_check("b2b", 8);

    // Degenerate duty
    setcfg(0, 1, 0, 3, 0, 2, 0);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
    drain_check("duty0", 0);
    setcfg(20, 1, 0, 3, 7, 2, 0);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
    drain_check("duty_clamp", 6);
    setcfg(5, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(1, 0, 0, 0);
    drain_check("zero_per_iter", 1);

    // Pause mid-period, then reset while a write is in flight
    setcfg(40, 1, 0, 4, 4, 3, 0);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    chk("pause_we_count", 64'(n_we - we_mark), 64'd4);
    cyc(1, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("arst_we", {63'd0, bus.we}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd1);
    chk("arst_addr", 64'(bus.addr), 64'd0);
`ifdef XWRADDRGEN_ERR_EN
    chk("arst_err", {63'd0, err}, 64'd0);
`endif
    sb.delete();
    m_active = 1'b0;
    m_err    = 1'b0;
    m_idx    = 0;
    m_skip   = 0;
    @(negedge clk);
    rst = 1'b1;
    we_mark = n_we;

    // Randomized configurations and traffic
    for (int k = 0; k < 20; k++) begin
      bit v, ps, rn;
      setcfg($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
             $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));
      v = ($urandom_range(0, 1) == 1);
      cyc(v, 0, 1, 1);
      for (int c = 0; c < 600 && m_active; c++) begin
        v  = ($urandom_range(0, 3) != 0);
        ps = ($urandom_range(0, 7) == 0);
        rn = (c < 300) && ($urandom_range(0, 7) == 0);
        cyc(v, ps, rn, 0);
      end
      chk("rand_done_budget", {63'd0, done}, 64'd1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("rand_pending", 64'(sb.size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
